// File: rtl/oflow_bbox_row_packer_if.sv
// rtl/oflow_bbox_row_packer_if.sv - bbox stream, row-write and end-pointer bundle for the row packer
interface oflow_bbox_row_packer_if #(
   parameter int BBOX_W = 64,
   parameter int ADDR_W = 8,
   parameter int HIST_W = 3
);
   logic                  bbox_valid;
   logic                  bbox_ready;
   logic [BBOX_W-1:0]     bbox_data;
   logic                  mem_we;
   logic                  mem_ready;
   logic [HIST_W-1:0]     mem_slot;
   logic [ADDR_W-1:0]     mem_addr;
   logic [2*BBOX_W-1:0]   mem_wdata;
   logic [1:0]            mem_half_en;
   logic                  end_ptr_we;
   logic [HIST_W-1:0]     end_ptr_slot;
   logic [ADDR_W-1:0]     end_ptr_value;

   // master is the packer side
   modport master (
      input  bbox_valid, bbox_data, mem_ready,
      output bbox_ready, mem_we, mem_slot, mem_addr, mem_wdata, mem_half_en,
             end_ptr_we, end_ptr_slot, end_ptr_value
   );

   modport slave (
      output bbox_valid, bbox_data, mem_ready,
      input  bbox_ready, mem_we, mem_slot, mem_addr, mem_wdata, mem_half_en,
             end_ptr_we, end_ptr_slot, end_ptr_value
   );
endinterface

// File: rtl/oflow_bbox_row_packer.sv
// rtl/oflow_bbox_row_packer.sv - packs bboxes two per memory row into a history-frame slot
module oflow_bbox_row_packer #(
   parameter int BBOX_W  = 64,
   parameter int ADDR_W  = 8,
   parameter int FRAME_W = 8,
   parameter int HIST_W  = 3,
   parameter int NBBOX_W = 7
) (
   input  logic                 clk,
   input  logic                 reset_N,
   input  logic                 start_frame,
   input  logic [FRAME_W-1:0]   frame_num,
   input  logic [HIST_W-1:0]    num_of_history_frames,
   input  logic [NBBOX_W-1:0]   num_of_bbox_in_frame,
   output logic                 done_write,
   output logic                 busy,
   oflow_bbox_row_packer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, LOAD, COLLECT_LO, COLLECT_HI, WRITE, FINISH
   } state_t;

   state_t               state, state_nx;
   logic [NBBOX_W-1:0]   n_reg, cnt, cnt_inc;
   logic [FRAME_W-1:0]   frame_reg;
   logic [HIST_W-1:0]    hist_reg, slot;
   logic [ADDR_W-1:0]    row;
   logic [BBOX_W-1:0]    lo_reg, hi_reg;
   logic [1:0]           mask;
   logic                 xfer, wr_active, fin_active;

   assign cnt_inc = cnt + 1'b1;
   assign xfer    = bus.bbox_valid & bus.bbox_ready;

   always_ff @(posedge clk) begin
      if (reset_N) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (start_frame) state_nx = LOAD;
         LOAD:       state_nx = (n_reg == '0) ? FINISH : COLLECT_LO;
         COLLECT_LO: if (xfer) state_nx = (cnt_inc == n_reg) ? WRITE : COLLECT_HI;
         COLLECT_HI: if (xfer) state_nx = WRITE;
         WRITE:      if (bus.mem_ready) state_nx = (cnt == n_reg) ? FINISH : COLLECT_LO;
         FINISH:     state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_N) begin
         n_reg     <= '0;
         frame_reg <= '0;
         hist_reg  <= '0;
         slot      <= '0;
         cnt       <= '0;
         row       <= '0;
         lo_reg    <= '0;
         hi_reg    <= '0;
         mask      <= '0;
      end else begin
         case (state)
            IDLE: if (start_frame) begin
               n_reg     <= num_of_bbox_in_frame;
               frame_reg <= frame_num;
               hist_reg  <= (num_of_history_frames == '0) ? HIST_W'(1) : num_of_history_frames;
            end
            LOAD: begin
               // hist_reg is never zero here, so the modulo is always defined
               slot <= HIST_W'(frame_reg % FRAME_W'(hist_reg));
               cnt  <= '0;
               row  <= '0;
            end
            COLLECT_LO: if (xfer) begin
               lo_reg <= bus.bbox_data;
               hi_reg <= '0;
               mask   <= 2'b01;
               cnt    <= cnt_inc;
            end
            COLLECT_HI: if (xfer) begin
               hi_reg <= bus.bbox_data;
               mask   <= 2'b11;
               cnt    <= cnt_inc;
            end
            WRITE: if (bus.mem_ready) row <= row + 1'b1;
            default: ;
         endcase
      end
   end

   // Data outputs are qualified by state so they read zero outside their strobe
   assign wr_active  = (state == WRITE);
   assign fin_active = (state == FINISH);

   assign bus.bbox_ready    = (state == COLLECT_LO) || (state == COLLECT_HI);
   assign bus.mem_we        = wr_active;
   assign bus.mem_slot      = wr_active ? slot : '0;
   assign bus.mem_addr      = wr_active ? row : '0;
   assign bus.mem_wdata     = wr_active ? {hi_reg, lo_reg} : '0;
   assign bus.mem_half_en   = wr_active ? mask : 2'b00;
   assign bus.end_ptr_we    = fin_active;
   assign bus.end_ptr_slot  = fin_active ? slot : '0;
   assign bus.end_ptr_value = fin_active ? row : '0;
   assign done_write        = fin_active;
   assign busy              = (state != IDLE);

endmodule

// File: tb/tb_oflow_bbox_row_packer.sv
// tb/tb_oflow_bbox_row_packer.sv - directed self-checking bench for the bbox row packer
module tb_oflow_bbox_row_packer;

   logic       clk = 1'b0;
   logic       reset_N = 1'b1;
   logic       start_frame = 1'b0;
   logic [7:0] frame_num = '0;
   logic [2:0] num_of_history_frames = '0;
   logic [6:0] num_of_bbox_in_frame = '0;
   logic       done_write, busy;

   int checks = 0;
   int errors = 0;

   oflow_bbox_row_packer_if #(.BBOX_W(64), .ADDR_W(8), .HIST_W(3)) bus ();

   oflow_bbox_row_packer #(
      .BBOX_W(64), .ADDR_W(8), .FRAME_W(8), .HIST_W(3), .NBBOX_W(7)
   ) dut (
      .clk                   (clk),
      .reset_N               (reset_N),
      .start_frame           (start_frame),
      .frame_num             (frame_num),
      .num_of_history_frames (num_of_history_frames),
      .num_of_bbox_in_frame  (num_of_bbox_in_frame),
      .done_write            (done_write),
      .busy                  (busy),
      .bus                   (bus)
   );

   always #5 clk = ~clk;

   // Monitor: logs row writes and end-pointer updates, timestamps start/done
   int           cyc = 0, start_cyc = 0, done_cyc = 0;
   int           wr_n = 0, ep_n = 0, stall_n = 0, stab_err = 0;
   logic [2:0]   wr_slot [64];
   logic [7:0]   wr_addr [64];
   logic [127:0] wr_data [64];
   logic [1:0]   wr_mask [64];
   logic [2:0]   ep_slot [16];
   logic [7:0]   ep_val  [16];
   logic         prev_stall = 1'b0;
   logic [7:0]   prev_addr = '0;
   logic [127:0] prev_data = '0;
   logic [1:0]   prev_mask = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (start_frame && !busy && !reset_N) start_cyc <= cyc;
      if (done_write) done_cyc <= cyc;
      if (bus.mem_we && bus.mem_ready) begin
         wr_slot[wr_n] <= bus.mem_slot;
         wr_addr[wr_n] <= bus.mem_addr;
         wr_data[wr_n] <= bus.mem_wdata;
         wr_mask[wr_n] <= bus.mem_half_en;
         wr_n <= wr_n + 1;
      end
      if (bus.end_ptr_we) begin
         ep_slot[ep_n] <= bus.end_ptr_slot;
         ep_val[ep_n]  <= bus.end_ptr_value;
         ep_n <= ep_n + 1;
      end
      if (bus.mem_we && !bus.mem_ready) stall_n <= stall_n + 1;
      if (prev_stall && bus.mem_we &&
          (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_data || bus.mem_half_en !== prev_mask))
         stab_err <= stab_err + 1;
      prev_stall <= bus.mem_we && !bus.mem_ready;
      prev_addr  <= bus.mem_addr;
      prev_data  <= bus.mem_wdata;
      prev_mask  <= bus.mem_half_en;
   end

   function automatic logic [63:0] bb(input int f, input int i);
      return {48'hB0B0_0000_0000, f[7:0], i[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input int n, input int f, input int h, input bit gap,
                            input int stall, input int glitch);
      int idx, ws, eb;
      bit gapped, xfer;
      idx = 0; ws = 0; gapped = 0; eb = ep_n;
      frame_num = f[7:0];
      num_of_history_frames = h[2:0];
      num_of_bbox_in_frame = n[6:0];
      start_frame = 1'b1;
      @(posedge clk); #1;
      start_frame = 1'b0;
      for (int c = 0; c < 200 && ep_n == eb; c++) begin
         if (c == glitch) begin
            start_frame = 1'b1;
            frame_num = 8'd3;
            num_of_history_frames = 3'd2;
            num_of_bbox_in_frame = 7'd2;
         end else start_frame = 1'b0;
         if (bus.mem_we && ws < stall) begin bus.mem_ready = 1'b0; ws++; end
         else begin bus.mem_ready = 1'b1; ws = 0; end
         bus.bbox_data = bb(f, idx);
         if (gap && bus.bbox_ready && !gapped) begin bus.bbox_valid = 1'b0; gapped = 1'b1; end
         else bus.bbox_valid = 1'b1;
         xfer = bus.bbox_valid && bus.bbox_ready;
         @(posedge clk); #1;
         if (xfer) begin idx++; gapped = 1'b0; end
      end
      start_frame = 1'b0;
      bus.bbox_valid = 1'b0;
      bus.mem_ready = 1'b1;
      chk("frame_done", ep_n - eb, 1);
      chk("accepted", idx, n);
   endtask

   initial begin
      int wb, eb, sb;
      bus.bbox_valid = 1'b0;
      bus.bbox_data = '0;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_N = 1'b0;

      chk("rst_busy", busy, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_bbox_ready", bus.bbox_ready, 0);
      chk("rst_end_ptr_we", bus.end_ptr_we, 0);
      chk("rst_done", done_write, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_end_ptr_value", bus.end_ptr_value, 0);

      // N=4, frame 7, hist 5 -> slot 2, two full rows
      wb = wr_n; eb = ep_n;
      run_frame(4, 7, 5, 0, 0, -1);
      chk("a_rows", wr_n - wb, 2);
      chk("a_slot0", wr_slot[wb], 2);
      chk("a_addr0", wr_addr[wb], 0);
      chk("a_data0", wr_data[wb], {64'hB0B0_0000_0000_0701, 64'hB0B0_0000_0000_0700});
      chk("a_mask0", wr_mask[wb], 2'b11);
      chk("a_addr1", wr_addr[wb+1], 1);
      chk("a_data1", wr_data[wb+1], {64'hB0B0_0000_0000_0703, 64'hB0B0_0000_0000_0702});
      chk("a_mask1", wr_mask[wb+1], 2'b11);
      chk("a_ep_slot", ep_slot[eb], 2);
      chk("a_ep_val", ep_val[eb], 2);
      chk("a_done_lat", done_cyc - start_cyc, 8);

      // N=3, frame 10, hist 3 -> slot 1, second row half
      wb = wr_n; eb = ep_n;
      run_frame(3, 10, 3, 0, 0, -1);
      chk("b_rows", wr_n - wb, 2);
      chk("b_slot1", wr_slot[wb+1], 1);
      chk("b_data0", wr_data[wb], {64'hB0B0_0000_0000_0A01, 64'hB0B0_0000_0000_0A00});
      chk("b_addr1", wr_addr[wb+1], 1);
      chk("b_data1", wr_data[wb+1], {64'h0, 64'hB0B0_0000_0000_0A02});
      chk("b_mask1", wr_mask[wb+1], 2'b01);
      chk("b_ep_slot", ep_slot[eb], 1);
      chk("b_ep_val", ep_val[eb], 2);
      chk("b_done_lat", done_cyc - start_cyc, 7);
      // extra bbox offered while idle is refused
      bus.bbox_valid = 1'b1;
      @(posedge clk); #1;
      chk("b_extra_ready", bus.bbox_ready, 0);
      chk("b_extra_rows", wr_n - wb, 2);
      bus.bbox_valid = 1'b0;

      // N=0, frame 5, hist 0 (treated as 1) -> slot 0, no rows
      wb = wr_n; eb = ep_n;
      run_frame(0, 5, 0, 0, 0, -1);
      chk("c_rows", wr_n - wb, 0);
      chk("c_ep_slot", ep_slot[eb], 0);
      chk("c_ep_val", ep_val[eb], 0);
      chk("c_done_lat", done_cyc - start_cyc, 2);

      // N=6, frame 9, hist 4 -> slot 1; 2 stall cycles per write, 1 valid gap per bbox
      wb = wr_n; eb = ep_n; sb = stall_n;
      run_frame(6, 9, 4, 1, 2, -1);
      chk("d_rows", wr_n - wb, 3);
      chk("d_slot", wr_slot[wb+2], 1);
      chk("d_addr2", wr_addr[wb+2], 2);
      chk("d_data2", wr_data[wb+2], {64'hB0B0_0000_0000_0905, 64'hB0B0_0000_0000_0904});
      chk("d_mask2", wr_mask[wb+2], 2'b11);
      chk("d_stalls", stall_n - sb, 6);
      chk("d_stable", stab_err, 0);
      chk("d_ep_val", ep_val[eb], 3);
      chk("d_done_lat", done_cyc - start_cyc, 23);

      // start_frame pulsed mid-frame with different parameters is ignored
      wb = wr_n; eb = ep_n;
      run_frame(4, 7, 5, 0, 0, 3);
      chk("e_rows", wr_n - wb, 2);
      chk("e_slot", wr_slot[wb+1], 2);
      chk("e_data1", wr_data[wb+1], {64'hB0B0_0000_0000_0703, 64'hB0B0_0000_0000_0702});
      chk("e_ep_slot", ep_slot[eb], 2);
      chk("e_ep_val", ep_val[eb], 2);
      chk("e_done_lat", done_cyc - start_cyc, 8);

      // reset after the first row of an N=6 frame aborts it
      wb = wr_n; eb = ep_n;
      frame_num = 8'd7; num_of_history_frames = 3'd5; num_of_bbox_in_frame = 7'd6;
      start_frame = 1'b1;
      @(posedge clk); #1;
      start_frame = 1'b0;
      bus.bbox_valid = 1'b1;
      bus.bbox_data = 64'hDEAD_BEEF_0000_0001;
      for (int c = 0; c < 40 && wr_n == wb; c++) begin
         @(posedge clk); #1;
      end
      chk("f_first_row", wr_n - wb, 1);
      reset_N = 1'b1;
      @(posedge clk); #1;
      reset_N = 1'b0;
      chk("f_busy", busy, 0);
      chk("f_mem_we", bus.mem_we, 0);
      chk("f_addr", bus.mem_addr, 0);
      chk("f_ready", bus.bbox_ready, 0);
      repeat (12) @(posedge clk);
      #1;
      chk("f_no_more_rows", wr_n - wb, 1);
      chk("f_no_end_ptr", ep_n - eb, 0);
      chk("f_idle_ready", bus.bbox_ready, 0);
      bus.bbox_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
